// File: rtl/atm_txn_engine_if.sv
// Session/operation handshake bundle between an ATM front end and atm_txn_engine.
// The front end drives requests and operations; the engine returns status and balance.
interface atm_txn_engine_if #(
  parameter int BAL_W = 32,
  parameter int PIN_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       acc_num;
  logic [PIN_W-1:0] pin;
  logic             op_valid;
  logic [2:0]       op;
  logic [BAL_W-1:0] amount;
  logic [PIN_W-1:0] new_pin;
  logic             done;
  logic             success;
  logic [2:0]       err_code;
  logic [BAL_W-1:0] balance;
  logic [2:0]       state;

  modport master (
    output req_valid, acc_num, pin, op_valid, op, amount, new_pin,
    input  req_ready, done, success, err_code, balance, state
  );

  modport slave (
    input  req_valid, acc_num, pin, op_valid, op, amount, new_pin,
    output req_ready, done, success, err_code, balance, state
  );
endinterface

// File: rtl/atm_txn_engine.sv
// ATM session engine: authenticates an account, runs one operation, reports status.
// Optional per-account wrong-PIN lockout is built when ATM_LOCKOUT_EN is defined.
module atm_txn_engine #(
  parameter int                NUM_ACCTS   = 16,
  parameter int                BAL_W       = 32,
  parameter int                PIN_W       = 16,
  parameter int unsigned       INIT_BAL    = 1000,
  parameter logic [PIN_W-1:0]  DEFAULT_PIN = PIN_W'(16'h1234),
  parameter int                TIMEOUT     = 64,
  parameter int                MAX_TRIES   = 3
) (
  input logic               clk,
  input logic               rst,
  atm_txn_engine_if.slave   bus
);

  localparam int ACC_W = ($clog2(NUM_ACCTS) < 1) ? 1 : $clog2(NUM_ACCTS);
  localparam int TMR_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  if (NUM_ACCTS < 2 || NUM_ACCTS > 256) begin : g_bad_accts
    $error("atm_txn_engine: NUM_ACCTS out of range");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("atm_txn_engine: TIMEOUT must be at least 2");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("atm_txn_engine: MAX_TRIES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AUTH = 3'd1,
    S_MENU = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [2:0] OP_BALANCE    = 3'd0;
  localparam logic [2:0] OP_WITHDRAW   = 3'd1;
  localparam logic [2:0] OP_DEPOSIT    = 3'd2;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd3;
  localparam logic [2:0] OP_EXIT       = 3'd4;

  localparam logic [2:0] E_OK       = 3'd0;
  localparam logic [2:0] E_BAD_ACC  = 3'd1;
  localparam logic [2:0] E_BAD_PIN  = 3'd2;
  localparam logic [2:0] E_LOCKED   = 3'd3;
  localparam logic [2:0] E_INSUFF   = 3'd4;
  localparam logic [2:0] E_OVERFLOW = 3'd5;
  localparam logic [2:0] E_BAD_OP   = 3'd6;
  localparam logic [2:0] E_TIMEOUT  = 3'd7;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [2:0]       op_q;
  logic [BAL_W-1:0] amt_q;
  logic [PIN_W-1:0] new_pin_q;
  logic [TMR_W-1:0] tmr_q;
  logic             done_q;
  logic             success_q;
  logic [2:0]       err_q;
  logic [BAL_W-1:0] bal_out_q;

  logic [BAL_W-1:0] bal_mem_q [NUM_ACCTS];
  logic [PIN_W-1:0] pin_mem_q [NUM_ACCTS];

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   dep_sum;
  logic             acc_ok;
  logic             pin_ok;
  logic             locked;

  logic [2:0]       exec_err_d;
  logic [BAL_W-1:0] exec_bal_d;
  logic             exec_bal_we;
  logic             exec_pin_we;

  assign cur_bal = bal_mem_q[acc_q];
  assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};
  assign acc_ok  = ({1'b0, bus.acc_num} < 9'(NUM_ACCTS));
  assign pin_ok  = (pin_q == pin_mem_q[acc_q]);

  // Operation outcome, evaluated against the latched account while in EXEC.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    exec_err_d  = E_OK;
    exec_bal_d  = cur_bal;
    exec_bal_we = 1'b0;
    exec_pin_we = 1'b0;
    case (op_q)
      OP_BALANCE, OP_EXIT: ;
      OP_WITHDRAW: begin
        if (amt_q > cur_bal) begin
          exec_err_d = E_INSUFF;
        end else begin
          exec_bal_d  = cur_bal - amt_q;
          exec_bal_we = 1'b1;
        end
      end
      OP_DEPOSIT: begin
        if (dep_sum[BAL_W]) begin
          exec_err_d = E_OVERFLOW;
        end else begin
          exec_bal_d  = dep_sum[BAL_W-1:0];
          exec_bal_we = 1'b1;
        end
      end
      OP_CHANGE_PIN: exec_pin_we = 1'b1;
      default:       exec_err_d = E_BAD_OP;
    endcase
  end

  // Account storage: balances and PINs return to their initial values on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this store must be reset element by element, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_mem_q[i] <= BAL_W'(INIT_BAL);
        pin_mem_q[i] <= DEFAULT_PIN;
      end
    end else if (state_q == S_EXEC) begin
      if (exec_bal_we) bal_mem_q[acc_q] <= exec_bal_d;
      if (exec_pin_we) pin_mem_q[acc_q] <= new_pin_q;
    end
  end

`ifdef ATM_LOCKOUT_EN
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [TRY_W-1:0]     tries_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q;

  assign locked = lock_q[acc_q];

  // Lock flags stick until reset; a good PIN on an unlocked account clears its count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        tries_q[i] <= '0;
      end
      lock_q <= '0;
    end else if (state_q == S_AUTH && !lock_q[acc_q]) begin
      if (pin_ok) begin
        tries_q[acc_q] <= '0;
      end else if (tries_q[acc_q] == TRY_W'(MAX_TRIES - 1)) begin
        tries_q[acc_q] <= TRY_W'(MAX_TRIES);
        lock_q[acc_q]  <= 1'b1;
      end else begin
        tries_q[acc_q] <= tries_q[acc_q] + 1'b1;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

  // Session FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q   <= S_IDLE;
      acc_q     <= '0;
      pin_q     <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      new_pin_q <= '0;
      tmr_q     <= '0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      err_q     <= E_OK;
      bal_out_q <= '0;
    end else begin
      done_q    <= 1'b0;
      success_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (acc_ok) begin
              acc_q   <= bus.acc_num[ACC_W-1:0];
              pin_q   <= bus.pin;
              state_q <= S_AUTH;
            end else begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              err_q     <= E_BAD_ACC;
              bal_out_q <= '0;
            end
          end
        end
        S_AUTH: begin
          if (locked) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= E_LOCKED;
            bal_out_q <= cur_bal;
          end else if (!pin_ok) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= E_BAD_PIN;
            bal_out_q <= cur_bal;
          end else begin
            tmr_q   <= '0;
            state_q <= S_MENU;
          end
        end
        S_MENU: begin
          if (bus.op_valid) begin
            op_q      <= bus.op;
            amt_q     <= bus.amount;
            new_pin_q <= bus.new_pin;
            state_q   <= S_EXEC;
          end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= E_TIMEOUT;
            bal_out_q <= cur_bal;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_EXEC: begin
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          success_q <= (exec_err_d == E_OK);
          err_q     <= exec_err_d;
          bal_out_q <= exec_bal_d;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.done      = done_q;
  assign bus.success   = success_q;
  assign bus.err_code  = err_q;
  assign bus.balance   = bal_out_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed bench for atm_txn_engine: sessions with hand-computed status, balance and latency.
// Latency counts the request cycle as cycle 1; the lockout section follows ATM_LOCKOUT_EN.
module tb_atm_txn_engine;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  atm_txn_engine_if #(.BAL_W(32), .PIN_W(16)) if_i ();

  atm_txn_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (if_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full session; op_valid is held from the request until done.
  task automatic session(input logic [7:0] acc, input logic [15:0] p, input logic use_op,
                         input logic [2:0] o, input logic [31:0] amt, input logic [15:0] np,
                         output int lat, output logic [2:0] err, output logic [31:0] bal,
                         output logic succ);
    int cyc;
    bit seen;
    @(negedge clk);
    if_i.req_valid = 1'b1;
    if_i.acc_num   = acc;
    if_i.pin       = p;
    if_i.op_valid  = use_op;
    if_i.op        = o;
    if_i.amount    = amt;
    if_i.new_pin   = np;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) if_i.req_valid = 1'b0;
      if (if_i.done) seen = 1'b1;
    end
    lat  = seen ? cyc + 1 : 0;
    err  = if_i.err_code;
    bal  = if_i.balance;
    succ = if_i.success;
    if_i.op_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, if_i.done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [2:0]  err;
    logic [31:0] bal;
    logic        succ;
    bit          hit_exec;
    bit          saw_done;

    rst            = 1'b0;
    if_i.req_valid = 1'b0;
    if_i.acc_num   = '0;
    if_i.pin       = '0;
    if_i.op_valid  = 1'b0;
    if_i.op        = '0;
    if_i.amount    = '0;
    if_i.new_pin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",    if_i.state,     0);
    check("rst_done",     if_i.done,      0);
    check("rst_success",  if_i.success,   0);
    check("rst_err",      if_i.err_code,  0);
    check("rst_balance",  if_i.balance,   0);
    check("rst_req_rdy",  if_i.req_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Withdraw 300 from 1000.
    session(8'd2, 16'h1234, 1'b1, 3'd1, 32'd300, 16'h0, lat, err, bal, succ);
    check("wd_lat",  lat,  5);
    check("wd_succ", succ, 1);
    check("wd_err",  err,  0);
    check("wd_bal",  bal,  700);

    // Deposit overflow and insufficient funds leave the balance intact.
    session(8'd3, 16'h1234, 1'b1, 3'd2, 32'hFFFF_FC18, 16'h0, lat, err, bal, succ);
    check("ovf_err",  err,  5);
    check("ovf_bal",  bal,  1000);
    check("ovf_succ", succ, 0);
    session(8'd3, 16'h1234, 1'b1, 3'd1, 32'd1001, 16'h0, lat, err, bal, succ);
    check("insuff_err", err, 4);
    check("insuff_bal", bal, 1000);

    // Deposit to exactly the maximum, then withdraw everything.
    session(8'd3, 16'h1234, 1'b1, 3'd2, 32'hFFFF_FC17, 16'h0, lat, err, bal, succ);
    check("dep_max_err", err, 0);
    check("dep_max_bal", bal, 32'hFFFF_FFFF);
    session(8'd3, 16'h1234, 1'b1, 3'd1, 32'hFFFF_FFFF, 16'h0, lat, err, bal, succ);
    check("wd_all_err", err, 0);
    check("wd_all_bal", bal, 0);

    // Account range boundaries.
    session(8'd20, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("acc20_lat", lat, 2);
    check("acc20_err", err, 1);
    check("acc20_bal", bal, 0);
    session(8'd16, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("acc16_err", err, 1);
    session(8'd15, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("acc15_lat", lat, 5);
    check("acc15_err", err, 0);
    check("acc15_bal", bal, 1000);

    // Illegal op and EXIT.
    session(8'd6, 16'h1234, 1'b1, 3'd5, 32'd10, 16'h0, lat, err, bal, succ);
    check("badop_err", err, 6);
    check("badop_bal", bal, 1000);
    session(8'd2, 16'h1234, 1'b1, 3'd4, 32'd10, 16'h0, lat, err, bal, succ);
    check("exit_err",  err,  0);
    check("exit_succ", succ, 1);
    check("exit_bal",  bal,  700);

    // Wrong PIN repeatedly on account 5.
    for (int i = 0; i < 3; i++) begin
      session(8'd5, 16'h0000, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
      check("badpin_lat", lat, 3);
      check("badpin_err", err, 2);
    end
    session(8'd5, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
`ifdef ATM_LOCKOUT_EN
    check("locked_lat", lat, 3);
    check("locked_err", err, 3);
`else
    check("nolock_lat", lat, 5);
    check("nolock_err", err, 0);
    check("nolock_bal", bal, 1000);
`endif

    // PIN change, old PIN rejected, then inactivity timeout.
    session(8'd1, 16'h1234, 1'b1, 3'd3, 32'd0, 16'hBEEF, lat, err, bal, succ);
    check("chpin_err", err, 0);
    session(8'd1, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("oldpin_err", err, 2);
    session(8'd1, 16'hBEEF, 1'b0, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("tmo_err", err, 7);
    check("tmo_lat", lat, 3 + 64);

    // Reset during EXEC of a withdrawal aborts it silently.
    @(negedge clk);
    if_i.req_valid = 1'b1;
    if_i.acc_num   = 8'd4;
    if_i.pin       = 16'h1234;
    if_i.op_valid  = 1'b1;
    if_i.op        = 3'd1;
    if_i.amount    = 32'd500;
    hit_exec = 1'b0;
    for (int c = 0; c < 10 && !hit_exec; c++) begin
      @(posedge clk);
      #1;
      if_i.req_valid = 1'b0;
      if (if_i.state == 3'd3) hit_exec = 1'b1;
    end
    check("reach_exec", {63'd0, hit_exec}, 64'd1);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (if_i.done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    check("abort_state",   if_i.state, 0);
    if_i.op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    session(8'd4, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("abort_bal4", bal, 1000);
    session(8'd2, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("rst_bal2", bal, 1000);
    session(8'd1, 16'h1234, 1'b1, 3'd0, 32'd0, 16'h0, lat, err, bal, succ);
    check("rst_pin1", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_txn_engine.md
ATM_TXN_ENGINE -- requirements
Module: atm_txn_engine

Interface
REQ-001 Parameter NUM_ACCTS, default 16, number of accounts held (2..256); ACC_W = clog2(NUM_ACCTS), min 1.
REQ-002 Parameter BAL_W, default 32, balance and amount width in bits.
REQ-003 Parameter PIN_W, default 16, PIN width in bits.
REQ-004 Parameter INIT_BAL, default 1000, reset value of every balance.
REQ-005 Parameter DEFAULT_PIN, default 16'h1234, reset value of every PIN.
REQ-006 Parameter TIMEOUT, default 64, MENU inactivity limit in cycles (>=2).
REQ-007 Parameter MAX_TRIES, default 3, consecutive wrong PINs before lockout (used only with lockout).
REQ-008 clk  input  1  clock, all state changes on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-low.
REQ-010 req_valid  input  1  session request; acc_num and pin sampled when req_valid && req_ready.
REQ-011 req_ready  output  1  high only in IDLE.
REQ-012 acc_num  input  8  account number; bits above ACC_W must be zero for a valid account.
REQ-013 pin  input  PIN_W  entered PIN.
REQ-014 op_valid  input  1  operation strobe, sampled only in MENU.
REQ-015 op  input  3  0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 CHANGE_PIN, 4 EXIT, 5-7 illegal.
REQ-016 amount  input  BAL_W  withdraw/deposit amount, sampled with op.
REQ-017 new_pin  input  PIN_W  replacement PIN, sampled with op.
REQ-018 done  output  1  one-cycle pulse ending every session.
REQ-019 success  output  1  equals done && err_code==0.
REQ-020 err_code  output  3  0 OK, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 OVERFLOW, 6 BAD_OP, 7 TIMEOUT; valid while done=1, held until next done.
REQ-021 balance  output  BAL_W  balance of the session account, updated when done pulses.
REQ-022 state  output  3  current FSM state encoding.

Function
REQ-023 States: IDLE=0, AUTH=1, MENU=2, EXEC=3, DONE=4; encodings 5-7 unreachable, and if entered shall go to IDLE next cycle.
REQ-024 IDLE: on req_valid with acc_num >= NUM_ACCTS, shall go DONE with err BAD_ACC; otherwise latch acc_num, pin and go AUTH.
REQ-025 AUTH (one cycle): latched pin matches stored PIN and account unlocked -> MENU; mismatch -> DONE with BAD_PIN; locked -> DONE with LOCKED.
REQ-026 MENU: on op_valid latch op/amount/new_pin and go EXEC; inactivity counter clears on entry, and after TIMEOUT cycles without op_valid -> DONE with TIMEOUT.
REQ-027 EXEC (one cycle): BALANCE no change; EXIT no change, OK; illegal op -> BAD_OP.
REQ-028 WITHDRAW: amount > balance -> INSUFF, balance unchanged; amount == balance allowed, result 0.
REQ-029 DEPOSIT: computed BAL_W+1 wide; carry out -> OVERFLOW, balance unchanged; no wrap-around ever stored.
REQ-030 CHANGE_PIN: stored PIN replaced by new_pin, OK.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE; one operation per session.
REQ-032 Latency: valid request to done = 5 cycles with op_valid held high (IDLE->AUTH->MENU->EXEC->DONE), 3 cycles for BAD_PIN/LOCKED, 2 for BAD_ACC.
REQ-033 req_valid outside IDLE and op_valid outside MENU shall be ignored.
REQ-034 balance output shall show the stored balance of the latched account after EXEC, including on errors.

Reset
REQ-035 While rst=0: state=IDLE, done=0, success=0, err_code=0, balance=0, all balances=INIT_BAL, all PINs=DEFAULT_PIN, fail counters=0, lock flags=0.
REQ-036 Reset mid-session aborts it without a done pulse; any EXEC not yet clocked has no effect.

Configuration
REQ-037 Macro ATM_LOCKOUT_EN defined: per-account wrong-PIN counter increments on BAD_PIN, clears on successful AUTH; reaching MAX_TRIES sets lock flag, cleared only by reset.
REQ-038 Macro ATM_LOCKOUT_EN undefined: no counters or lock flags, LOCKED never reported, unlimited retries.

Verification
REQ-039 Reset, acc 2, pin 0x1234, op WITHDRAW 300 -> done 5 cycles after request, success=1, balance=700.
REQ-040 Acc 3 DEPOSIT 2^32-1000 (BAL_W=32) -> err_code=5, balance=1000 unchanged; WITHDRAW 1001 -> err_code=4, balance=1000.
REQ-041 Acc 20 (NUM_ACCTS=16) -> done 2 cycles later, err_code=1, balance=0.
REQ-042 With ATM_LOCKOUT_EN: acc 5, pin 0x0000 three times -> err 2,2,2; then pin 0x1234 -> err 3; without macro -> MENU.
REQ-043 Acc 1 CHANGE_PIN 0xBEEF -> OK; pin 0x1234 -> err 2; pin 0xBEEF, no op for 64 cycles -> err 7.
REQ-044 rst low while in EXEC of WITHDRAW 500 on acc 4 -> no done pulse, acc 4 balance 1000 after reset.
